sprite_palette_arbiter: RTL and testbench
=========================================

# sprite_palette_arbiter

Shares one banked sprite palette lookup between up to NUM_REQ sprite pixel requesters (Mario, enemies, items) in the sprite render path. Each cycle the block round-robin grants at most one pending request and translates its 4-bit colour index through the selected palette bank. It returns 4-bit R/G/B one cycle later, tagged with the requester ID. A configuration write port reloads palette entries at runtime, for example for power-up colour swaps.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- NUM_BANKS, 4: palette banks of 16 entries × 12 bits each.
- Clk  in  1  system clock; all logic is rising-edge.
- Reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester lookup request.
- req_index  in  NUM_REQ×4  colour index per requester.
- req_bank  in  NUM_REQ×clog2(NUM_BANKS)  palette bank per requester.
- gnt  out  NUM_REQ  one-hot grant; combinational, same cycle as the request.
- out_valid  out  1  lookup result valid.
- out_id  out  clog2(NUM_REQ)  requester that owns the result.
- red, green, blue  out  4 each  looked-up colour.
- cfg_we  in  1  palette write strobe.
- cfg_bank  in  clog2(NUM_BANKS)  bank to write.
- cfg_addr  in  4  entry to write.
- cfg_data  in  12  {R,G,B} value to write.

## Operation
- Requester protocol:
  - A requester asserts req[i] with stable req_index/req_bank and holds them until gnt[i]=1.
  - A grant consumes the request. The requester may deassert, or keep req high for a new lookup next cycle.
- Arbitration:
  - Round-robin. The search starts at rr_ptr and wraps modulo NUM_REQ.
  - On each grant, rr_ptr ← (granted ID + 1) mod NUM_REQ.
  - No grant leaves rr_ptr unchanged.
  - gnt is zero-or-one-hot. It is never asserted to a requester whose req=0.
- Config write priority: when cfg_we=1, gnt is all-zero that cycle and no lookup is issued. The write commits at the clock edge.
- Palette storage:
  - Flop array NUM_BANKS×16×12.
  - Reset loads every bank with DEFAULT_PALETTE.
- Lookup:
  - Granted {bank, index} reads the array.
  - On the next edge, {red, green, blue}, out_id and out_valid=1 are registered.
  - With no grant, out_valid←0 and colour/out_id hold their previous values.
- Bank out of range (NUM_BANKS not a power of two): read returns 12'h000.

## Timing
- Grant to result: exactly 1 cycle. Throughput is 1 lookup/cycle.
- Reset values:
  - out_valid=0, out_id=0, red/green/blue=0, gnt=0.
  - rr_ptr=0, so requester 0 has highest priority after reset.
  - Palette = DEFAULT_PALETTE.
- Reset asserted mid-operation:
  - The in-flight result is dropped; out_valid=0 the next cycle.
  - Pending requests are not granted while Reset_n=0.
  - Prior cfg writes are lost (palette reverts to default).
- Write/read same entry:
  - Simultaneous write and read cannot occur, because a write blocks the grant.
  - A lookup granted in the cycle after a write sees the new value.
- All requesters asserted continuously: grants rotate 0,1,…,NUM_REQ−1,0 with no gaps. Starvation bound is NUM_REQ−1 cycles plus cfg_we cycles.

## Configuration
- SPRITE_TRANSPARENCY_EN:
  - Defined: adds output out_transparent (1 bit, reset 0), registered alongside red/green/blue. It is set when the granted req_index==4'h0. Index 0 is the transparent key.
  - Not defined: the port is absent and index 0 is an ordinary colour.

## Structure
- Package sprite_pkg:
  - rgb12_t typedef (packed {r,g,b} 4-bit each).
  - DEFAULT_PALETTE: 16×rgb12_t = 660, 99F, E92, B32, 99F, 99F, 99F, 660, E92, 660, 99F, E92, E92, E92, 660, E92.
  - MAX_REQ constant.
- Sub-module rr_arbiter: holds rr_ptr and produces the one-hot grant. It has an enable input driven by !cfg_we. It is reusable for tile-fetch arbitration.

## Test plan
- Reset, then req[1]=1, index=2, bank=0 → gnt=0010 same cycle; next cycle out_valid=1, out_id=1, RGB=E,9,2.
- req=1111 held 8 cycles → gnt sequence 0001,0010,0100,1000,0001,…; out_id trails by one cycle.
- cfg_we=1 (bank 2, addr 5, data 12'h0F0) with req[0]=1 → gnt=0 that cycle. Next cycle gnt[0]=1 for bank 2, index 5; result 0,F,0.
- Grant to requester 3 in cycle N, Reset_n=0 in cycle N+1 → out_valid=0, palette bank 2 entry 5 back to 99F, rr_ptr=0.
- With SPRITE_TRANSPARENCY_EN: index 0 → out_transparent=1, RGB=6,6,0; index 1 → out_transparent=0.
- Idle cycle between lookups → out_valid=0 and RGB holds the last value.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette lookup path.
// Provides rgb12_t, the power-on palette and the requester limit.
package sprite_pkg;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t DEFAULT_PALETTE [16] = '{
    12'h660, 12'h99F, 12'hE92, 12'hB32,
    12'h99F, 12'h99F, 12'h99F, 12'h660,
    12'hE92, 12'h660, 12'h99F, 12'hE92,
    12'hE92, 12'hE92, 12'h660, 12'hE92
  };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: zero-or-one-hot grant, search starts at rr_ptr.
// Ports: Clk, Reset_n (sync low), en, req -> gnt, gnt_id, gnt_valid.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  logic [IDW-1:0] rr_ptr;

  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    gnt_id = '0;
    gnt_valid = 1'b0;
    // no grants while held in reset
    if (en && Reset_n) begin
      for (int off = 0; off < N; off++) begin
        k = int'(rr_ptr) + off;
        if (k >= N) k = k - N;
        if (!gnt_valid && req[k]) begin
          gnt_valid = 1'b1;
          gnt_id = IDW'(k);
          gnt[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      rr_ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Shared banked sprite palette lookup with round-robin requesters.
// Ports: req/req_index/req_bank -> gnt; out_valid/out_id/red/green/blue
// one cycle later; cfg_* palette write port (blocks grants that cycle).
// Option SPRITE_TRANSPARENCY_EN adds out_transparent (index 0 key).
module sprite_palette_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BANKS = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*4-1:0]  req_index,
  input  logic [NUM_REQ*BW-1:0] req_bank,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
`ifdef SPRITE_TRANSPARENCY_EN
  output logic                  out_transparent,
`endif
  input  logic                  cfg_we,
  input  logic [BW-1:0]         cfg_bank,
  input  logic [3:0]            cfg_addr,
  input  logic [11:0]           cfg_data
);

  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic [3:0]     sel_idx;
  logic [BW-1:0]  sel_bank;
  rgb12_t         rd;
  rgb12_t         col;
  rgb12_t         pal [NUM_BANKS][16];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .en        (!cfg_we),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign sel_idx  = req_index[int'(gnt_id)*4 +: 4];
  assign sel_bank = req_bank[int'(gnt_id)*BW +: BW];

  // banks past NUM_BANKS read as black
  always_comb begin
    rd = '0;
    if (int'(sel_bank) < NUM_BANKS) rd = pal[sel_bank][sel_idx];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < 16; e++)
          pal[b][e] <= DEFAULT_PALETTE[e];
    end else if (cfg_we && int'(cfg_bank) < NUM_BANKS) begin
      pal[cfg_bank][cfg_addr] <= rgb12_t'(cfg_data);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_id <= '0;
      col <= '0;
    end else begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_id <= gnt_id;
        col <= rd;
      end
    end
  end

`ifdef SPRITE_TRANSPARENCY_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) out_transparent <= 1'b0;
    else if (gnt_valid) out_transparent <= (sel_idx == 4'h0);
  end
`endif

  assign red   = col.r;
  assign green = col.g;
  assign blue  = col.b;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed table-driven bench for sprite_palette_arbiter.
// Each row is one cycle: gnt checked mid-cycle, outputs after the edge.
module tb_sprite_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [15:0] req_index;
  logic [7:0]  req_bank;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [3:0]  red, green, blue;
  logic        cfg_we;
  logic [1:0]  cfg_bank;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;
`ifdef SPRITE_TRANSPARENCY_EN
  logic        out_transparent;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  sprite_palette_arbiter #(.NUM_REQ(4), .NUM_BANKS(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_index (req_index),
    .req_bank  (req_bank),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_id    (out_id),
    .red       (red),
    .green     (green),
    .blue      (blue),
`ifdef SPRITE_TRANSPARENCY_EN
    .out_transparent (out_transparent),
`endif
    .cfg_we    (cfg_we),
    .cfg_bank  (cfg_bank),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] idx;
    logic [7:0]  bank;
    logic        we;
    logic [1:0]  wbank;
    logic [3:0]  waddr;
    logic [11:0] wdata;
    logic [3:0]  e_gnt;
    logic        e_valid;
    logic [1:0]  e_id;
    logic [11:0] e_rgb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic r, logic [3:0] q, logic [15:0] ix,
      logic [7:0] bk, logic w, logic [1:0] wb, logic [3:0] wa,
      logic [11:0] wd, logic [3:0] eg, logic ev, logic [1:0] ei,
      logic [11:0] ec);
    vec_t v;
    v.rst_n = r; v.req = q; v.idx = ix; v.bank = bk;
    v.we = w; v.wbank = wb; v.waddr = wa; v.wdata = wd;
    v.e_gnt = eg; v.e_valid = ev; v.e_id = ei; v.e_rgb = ec;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    @(negedge Clk);
    Reset_n = v.rst_n; req = v.req; req_index = v.idx;
    req_bank = v.bank; cfg_we = v.we; cfg_bank = v.wbank;
    cfg_addr = v.waddr; cfg_data = v.wdata;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(v.e_gnt));
    @(posedge Clk);
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(v.e_valid));
    check({tag, ".id"}, 32'(out_id), 32'(v.e_id));
    check({tag, ".rgb"}, 32'({red, green, blue}), 32'(v.e_rgb));
  endtask

  initial begin
    Reset_n = 1'b0; req = '0; req_index = '0; req_bank = '0;
    cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0; cfg_data = '0;

    // reset with requests pending: no grants, outputs cleared
    run(mk(0, 4'hF, 16'h0, 8'h0, 0, 0, 0, 0, 4'h0, 0, 0, 12'h000),
        "rst0");
    run(mk(0, 4'h0, 16'h0, 8'h0, 0, 0, 0, 0, 4'h0, 0, 0, 12'h000),
        "rst1");

    // single request, then rotation from rr_ptr=2
    tbl.push_back(mk(1, 4'b0010, 16'h0020, 8'h00, 0, 0, 0, 0,
                     4'b0010, 1, 1, 12'hE92));
    for (int c = 0; c < 8; c++) begin
      logic [3:0]  g;
      logic [11:0] col;
      logic [1:0]  id;
      id = 2'((c + 2) % 4);
      g = 4'b0001 << id;
      unique case (id)
        2'd0: col = 12'h660;
        2'd1: col = 12'hE92;
        2'd2: col = 12'h99F;
        default: col = 12'hB32;
      endcase
      tbl.push_back(mk(1, 4'hF, 16'h3120, 8'h00, 0, 0, 0, 0,
                       g, 1, id, col));
    end
    // idle: valid drops, colour and id hold
    tbl.push_back(mk(1, 4'h0, 16'h0, 8'h00, 0, 0, 0, 0,
                     4'h0, 0, 1, 12'hE92));
    // write blocks grant, next cycle sees new value
    tbl.push_back(mk(1, 4'b0001, 16'h0005, 8'h02, 1, 2, 5, 12'h0F0,
                     4'h0, 0, 1, 12'hE92));
    tbl.push_back(mk(1, 4'b0001, 16'h0005, 8'h02, 0, 0, 0, 0,
                     4'b0001, 1, 0, 12'h0F0));
    // other bank untouched
    tbl.push_back(mk(1, 4'b1000, 16'h2000, 8'hC0, 0, 0, 0, 0,
                     4'b1000, 1, 3, 12'hE92));
    tbl.push_back(mk(1, 4'b1001, 16'h0005, 8'h02, 0, 0, 0, 0,
                     4'b0001, 1, 0, 12'h0F0));
    // grant to 3 reading the written entry, then reset
    tbl.push_back(mk(1, 4'b1000, 16'h5000, 8'h80, 0, 0, 0, 0,
                     4'b1000, 1, 3, 12'h0F0));
    tbl.push_back(mk(0, 4'hF, 16'h5005, 8'h82, 0, 0, 0, 0,
                     4'h0, 0, 0, 12'h000));
    // after reset: rr_ptr=0, bank 2 entry 5 back to default
    tbl.push_back(mk(1, 4'hF, 16'h5005, 8'h82, 0, 0, 0, 0,
                     4'b0001, 1, 0, 12'h99F));
    tbl.push_back(mk(1, 4'hF, 16'h5005, 8'h82, 0, 0, 0, 0,
                     4'b0010, 1, 1, 12'h660));
    tbl.push_back(mk(1, 4'b0101, 16'h0001, 8'h00, 0, 0, 0, 0,
                     4'b0100, 1, 2, 12'h660));
    tbl.push_back(mk(1, 4'b0101, 16'h0001, 8'h00, 0, 0, 0, 0,
                     4'b0001, 1, 0, 12'h99F));

    foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

`ifdef SPRITE_TRANSPARENCY_EN
    run(mk(1, 4'b0001, 16'h0000, 8'h00, 0, 0, 0, 0,
           4'b0001, 1, 0, 12'h660), "tr0");
    check("tr0.transp", 32'(out_transparent), 32'd1);
    run(mk(1, 4'b0001, 16'h0001, 8'h00, 0, 0, 0, 0,
           4'b0001, 1, 0, 12'h99F), "tr1");
    check("tr1.transp", 32'(out_transparent), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
